param_event_counter: RTL and testbench

Parametrised up/down event counter with a programmable terminal value, wrap or saturate mode, parallel load, and a programmable target compare with a sticky "reached" flag. Generalises the fixed 4-bit free-running count-to-9 check into a reusable block for event counting and timeout detection. Sits beside the control logic that consumes the count, tc, wrap and hit status. Optional built-in concurrent assertions are included.

---
 rtl/param_event_counter.sv | 147 ++++++++++++++
 tb/tb_param_event_counter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/param_event_counter.sv
// param_event_counter
//   Parametrised up/down event counter. It has a programmable terminal value
//   (MAX_COUNT), wrap or saturate behaviour at the bounds, a parallel load, and
//   a target compare with a sticky "reached" flag.
//
// Ports:
//   clk       rising-edge clock
//   RST       synchronous, active-high reset (overrides load and en)
//   en        count enable, one step per cycle
//   up_dn     1 = up, 0 = down
//   load      parallel load strobe (beats en)
//   load_val  load value, clamped to MAX_COUNT
//   target    compare value for match/hit
//   clr_hit   clears sticky hit (a same-cycle match wins)
//   count     registered count
//   tc        pulse: count stepped onto MAX_COUNT (up) or 0 (down)
//   wrap      pulse: count wrapped at a bound (SATURATE=0)
//   sat       pulse: step blocked at a bound (SATURATE=1)
//   match     pulse: a step or load produced count == target
//   hit       sticky match flag
//
// Optional: define PARAM_EVENT_COUNTER_ASSERT_EN to compile in concurrent
// assertions and a cover property.
module param_event_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 9,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] target,
  input  logic             clr_hit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat,
  output logic             match,
  output logic             hit
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic [WIDTH-1:0] count_d, count_q;
  logic             tc_d, tc_q;
  logic             wrap_d, wrap_q;
  logic             sat_d, sat_q;
  logic             match_d, match_q;
  logic             hit_d, hit_q;
  // Set when this cycle writes a new value into the counter (load or
  // unblocked step); only then may match fire.
  logic             moved;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;
    moved   = 1'b0;

    if (load) begin
      count_d = (load_val > MaxVal) ? MaxVal : load_val;
      moved   = 1'b1;
    end else if (en) begin
      if (up_dn) begin
        if (count_q < MaxVal) begin
          count_d = count_q + One;
          tc_d    = (count_d == MaxVal);
          moved   = 1'b1;
        end else if (SATURATE) begin
          sat_d = 1'b1;
        end else begin
          count_d = '0;
          wrap_d  = 1'b1;
          moved   = 1'b1;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - One;
          tc_d    = (count_d == '0);
          moved   = 1'b1;
        end else if (SATURATE) begin
          sat_d = 1'b1;
        end else begin
          count_d = MaxVal;
          wrap_d  = 1'b1;
          moved   = 1'b1;
        end
      end
    end

    // count_d never exceeds MaxVal, so an out-of-range target cannot match.
    match_d = moved && (count_d == target);
    hit_d   = match_d | (hit_q & ~clr_hit);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
      match_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
      match_q <= match_d;
      hit_q   <= hit_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign wrap  = wrap_q;
  assign sat   = sat_q;
  assign match = match_q;
  assign hit   = hit_q;

`ifdef PARAM_EVENT_COUNTER_ASSERT_EN
  a_count_range: assert property (@(posedge clk) disable iff (RST) count_q <= MaxVal)
    else $display("a_count_range failed: count=%0d", count_q);

  a_reset: assert property (@(posedge clk) RST |=> (count_q == '0 && !hit_q))
    else $display("a_reset failed: count=%0d", count_q);

  a_step_up: assert property (@(posedge clk) disable iff (RST)
      (en && !load && up_dn && count_q < MaxVal) |=> count_q == $past(count_q) + One)
    else $display("a_step_up failed: count=%0d", count_q);

  // Each tc/wrap/sat pulse must be backed by a step sampled the cycle before;
  // a flag cannot linger on its own.
  a_pulse: assert property (@(posedge clk) disable iff (RST)
      (tc_q || wrap_q || sat_q) |-> $past(en && !load))
    else $display("a_pulse failed: count=%0d", count_q);

  c_target: cover property (@(posedge clk) disable iff (RST) en && match_q)
    $display("c_target reached: count=%0d", count_q);
`endif

endmodule

// File: tb/tb_param_event_counter.sv
module tb_param_event_counter;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] target = '0;
  logic       clr_hit = 1'b0;

  logic [3:0] w_count, s_count;
  logic       w_tc, w_wrap, w_sat, w_match, w_hit;
  logic       s_tc, s_wrap, s_sat, s_match, s_hit;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: plain integers, one set per configuration.
  int w_cnt = 0, s_cnt = 0;
  bit w_h = 0, s_h = 0;
  bit w_etc, w_ewr, w_esa, w_ema;
  bit s_etc, s_ewr, s_esa, s_ema;

  always #5 clk = ~clk;

  param_event_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .RST(RST), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .target(target), .clr_hit(clr_hit), .count(w_count), .tc(w_tc), .wrap(w_wrap),
    .sat(w_sat), .match(w_match), .hit(w_hit)
  );

  param_event_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .RST(RST), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .target(target), .clr_hit(clr_hit), .count(s_count), .tc(s_tc), .wrap(s_wrap),
    .sat(s_sat), .match(s_match), .hit(s_hit)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Behavioural model of one clock edge, MAX_COUNT = 9.
  task automatic model(input bit sat_mode, inout int cnt, inout bit h,
                       output bit etc, output bit ewr, output bit esa, output bit ema);
    int nxt;
    etc = 0; ewr = 0; esa = 0; ema = 0;
    if (RST) begin
      cnt = 0;
      h   = 0;
      return;
    end
    if (load) begin
      cnt = (int'(load_val) > 9) ? 9 : int'(load_val);
      ema = (cnt == int'(target));
    end else if (en) begin
      nxt = up_dn ? cnt + 1 : cnt - 1;
      if (nxt > 9 || nxt < 0) begin
        if (sat_mode) esa = 1;
        else begin
          cnt = up_dn ? 0 : 9;
          ewr = 1;
          ema = (cnt == int'(target));
        end
      end else begin
        cnt = nxt;
        etc = up_dn ? (cnt == 9) : (cnt == 0);
        ema = (cnt == int'(target));
      end
    end
    h = ema | (h & ~clr_hit);
  endtask

  task automatic cycle(input bit r, input bit e, input bit u, input bit ld,
                       input logic [3:0] lv, input logic [3:0] tg, input bit cl);
    @(negedge clk);
    RST = r; en = e; up_dn = u; load = ld; load_val = lv; target = tg; clr_hit = cl;
    @(posedge clk);
    model(1'b0, w_cnt, w_h, w_etc, w_ewr, w_esa, w_ema);
    model(1'b1, s_cnt, s_h, s_etc, s_ewr, s_esa, s_ema);
    #1;
    check("wrap.count", int'(w_count), w_cnt);
    check("wrap.tc",    int'(w_tc),    int'(w_etc));
    check("wrap.wrap",  int'(w_wrap),  int'(w_ewr));
    check("wrap.sat",   int'(w_sat),   int'(w_esa));
    check("wrap.match", int'(w_match), int'(w_ema));
    check("wrap.hit",   int'(w_hit),   int'(w_h));
    check("sat.count",  int'(s_count), s_cnt);
    check("sat.tc",     int'(s_tc),    int'(s_etc));
    check("sat.wrap",   int'(s_wrap),  int'(s_ewr));
    check("sat.sat",    int'(s_sat),   int'(s_esa));
    check("sat.match",  int'(s_match), int'(s_ema));
    check("sat.hit",    int'(s_hit),   int'(s_h));
  endtask

  initial begin
    // 1: reset, then count up to 9 and wrap (saturating copy holds at 9).
    repeat (4) cycle(1, 0, 1, 0, 4'd0, 4'd9, 0);
    check("tp1.reset_count", int'(w_count), 0);
    for (int i = 1; i <= 10; i++) cycle(0, 1, 1, 0, 4'd0, 4'd9, 0);
    check("tp1.wrapped_to_0", int'(w_count), 0);
    check("tp1.sat_held_9", int'(s_count), 9);
    // 2: load 8 then three up steps.
    cycle(0, 0, 1, 1, 4'd8, 4'd9, 0);
    repeat (3) cycle(0, 1, 1, 0, 4'd0, 4'd9, 0);
    check("tp2.sat_pulse", int'(s_sat), 1);
    // 3: load 2, count down through 0.
    cycle(0, 0, 0, 1, 4'd2, 4'd3, 0);
    repeat (3) cycle(0, 1, 0, 0, 4'd0, 4'd3, 0);
    check("tp3.down_wrap_9", int'(w_count), 9);
    // 4: load beats en; 15 clamps to 9.
    cycle(0, 1, 1, 1, 4'd15, 4'd9, 0);
    check("tp4.clamp", int'(w_count), 9);
    // 5: clear and match together keep hit; clear alone drops it.
    cycle(0, 0, 1, 1, 4'd9, 4'd9, 1);
    check("tp5.set_wins", int'(w_hit), 1);
    cycle(0, 0, 1, 0, 4'd0, 4'd9, 1);
    check("tp5.cleared", int'(w_hit), 0);
    // 6: reset mid-count overrides load and en.
    cycle(0, 0, 1, 1, 4'd5, 4'd5, 0);
    cycle(1, 1, 1, 1, 4'd7, 4'd5, 0);
    check("tp6.reset_count", int'(w_count), 0);
    // A target change while static must not match.
    cycle(0, 0, 1, 0, 4'd0, 4'd0, 0);
    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 75), 1'($urandom),
            ($urandom_range(0, 99) < 8), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 11)), ($urandom_range(0, 99) < 10));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
